ddr_sample_tx: RTL and testbench

Transmit-side counterpart of the ADS5404 capture path: accepts two samples per clock from user logic through a valid/ready handshake, buffers them in a small FIFO and streams them as registered word pairs (rising/falling-edge samples) with frame and sync markers. It drives a DAC or a loopback emulator of the ADC data bus. A separate pin-stage sub-module converts each word pair to DDR LVDS.

---
 rtl/ddr_sample_pkg.sv | 16 +
 rtl/ddr_sample_oddr.sv | 58 +++++
 rtl/ddr_sample_tx.sv | 173 +++++++++++++++++
 tb/tb_ddr_sample_tx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_sample_pkg.sv
// Shared definitions for the DDR sample transmit path: FSM state encoding,
// state width and the code driven onto the sample bus when no data is sent.
package ddr_sample_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } tx_state_t;

    // Midscale in two's complement is all zeros.
    localparam int MIDSCALE_CODE = 0;

endpackage

// File: rtl/ddr_sample_oddr.sv
// Pin stage: turns a registered word pair into a DDR differential bus.
// d0 is driven while clk is high, d1 while clk is low. Frame and sync are
// held for the whole cycle; the forwarded clock is edge-aligned with data.
// This stage is instantiated by the board wrapper, outside ddr_sample_tx.
module ddr_sample_oddr #(
    parameter int NBITS = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NBITS-1:0] d0,
    input  logic [NBITS-1:0] d1,
    input  logic             frame,
    input  logic             sync,
    output logic [NBITS-1:0] dq_p,
    output logic [NBITS-1:0] dq_n,
    output logic             frame_p,
    output logic             frame_n,
    output logic             sync_p,
    output logic             sync_n,
    output logic             clk_p,
    output logic             clk_n
);

    logic [NBITS-1:0] r0;
    logic [NBITS-1:0] r1;
    logic             rf;
    logic             rs;
    logic [NBITS-1:0] dq;

    // Capture the pair and markers on the rising edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r0 <= '0;
            r1 <= '0;
            rf <= 1'b0;
            rs <= 1'b0;
        end else begin
            r0 <= d0;
            r1 <= d1;
            rf <= frame;
            rs <= sync;
        end
    end

    // Double-data-rate mux followed by differential buffers.
    always_comb begin
        dq      = clk ? r0 : r1;
        dq_p    = dq;
        dq_n    = ~dq;
        frame_p = rf;
        frame_n = ~rf;
        sync_p  = rs;
        sync_n  = ~rs;
        clk_p   = clk;
        clk_n   = ~clk;
    end

endmodule

// File: rtl/ddr_sample_tx.sv
// Transmit-side sample streamer: two samples per clock enter through a
// valid/ready handshake into a small FIFO and leave as registered word pairs
// with frame and sync markers.
// Optional ramp test pattern: define DDR_SAMPLE_TX_PATTERN_EN.
//
// state | meaning
// IDLE  | FIFO flushed, outputs at midscale, waiting for tx_enable
// PRIME | filling FIFO to half depth before streaming
// RUN   | one pair popped and emitted per cycle
module ddr_sample_tx
    import ddr_sample_pkg::*;
#(
    parameter int NBITS       = 12,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_PERIOD = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tx_enable,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [NBITS-1:0]   s_d0,
    input  logic [NBITS-1:0]   s_d1,
    input  logic               sync_req,
    input  logic               pattern_sel,
    output logic [NBITS-1:0]   tx_d0,
    output logic [NBITS-1:0]   tx_d1,
    output logic               tx_frame,
    output logic               tx_sync,
    output logic               underflow,
    output logic [STATE_W-1:0] state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int FRM_W = $clog2(SYNC_PERIOD);
    localparam logic [NBITS-1:0] IDLE_CODE = NBITS'(MIDSCALE_CODE);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(FIFO_DEPTH / 2);

    tx_state_t          st_q;
    tx_state_t          st_d;
    logic [2*NBITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   fifo_cnt;
    logic [FRM_W-1:0]   frame_cnt;
    logic               sync_pend;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               pat_on;
    logic               run_out;
    logic               mark_frame;

`ifdef DDR_SAMPLE_TX_PATTERN_EN
    logic [NBITS-1:0] ramp;

    assign pat_on = pattern_sel;

    // Ramp restarts at zero every time RUN is entered.
    always_ff @(posedge clk) begin
        if (!rst_n || st_q != ST_RUN) begin
            ramp <= '0;
        end else if (run_out) begin
            ramp <= ramp + NBITS'(2);
        end
    end
`else
    logic unused_pattern_sel;

    assign unused_pattern_sel = pattern_sel;
    assign pat_on             = 1'b0;
`endif

    assign fifo_empty = (fifo_cnt == '0);
    assign s_ready    = rst_n && tx_enable && (fifo_cnt != CNT_FULL);
    assign push       = s_valid && s_ready;
    // A word is emitted this cycle: FIFO data, or the ramp in pattern mode.
    assign run_out    = (st_q == ST_RUN) && tx_enable && (pat_on || !fifo_empty);
    assign pop        = run_out && !pat_on;
    assign mark_frame = run_out && (frame_cnt == '0);
    assign state      = st_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q <= ST_IDLE;
        end else begin
            st_q <= st_d;
        end
    end

    // Next-state logic; dropping tx_enable always returns to IDLE.
    always_comb begin
        st_d = st_q;
        if (!tx_enable) begin
            st_d = ST_IDLE;
        end else begin
            case (st_q)
                ST_IDLE:  st_d = pat_on ? ST_RUN : ST_PRIME;
                ST_PRIME: if (pat_on || fifo_cnt >= CNT_HALF) st_d = ST_RUN;
                ST_RUN:   if (!pat_on && fifo_empty) st_d = ST_PRIME;
                default:  st_d = ST_IDLE;
            endcase
        end
    end

    // FIFO storage; entries need no reset because the count gates reads.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {s_d1, s_d0};
        end
    end

    // FIFO pointers and count; cleared whenever the run request drops.
    always_ff @(posedge clk) begin
        if (!rst_n || !tx_enable) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Output word, frame/sync markers, frame counter and sticky underflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_d0     <= IDLE_CODE;
            tx_d1     <= IDLE_CODE;
            tx_frame  <= 1'b0;
            tx_sync   <= 1'b0;
            frame_cnt <= '0;
            sync_pend <= 1'b0;
            underflow <= 1'b0;
        end else begin
            tx_d0 <= IDLE_CODE;
            tx_d1 <= IDLE_CODE;
            if (pop) begin
                tx_d0 <= fifo_mem[rd_ptr][NBITS-1:0];
                tx_d1 <= fifo_mem[rd_ptr][2*NBITS-1:NBITS];
            end
`ifdef DDR_SAMPLE_TX_PATTERN_EN
            else if (run_out) begin
                tx_d0 <= ramp;
                tx_d1 <= ramp + NBITS'(1);
            end
`endif
            tx_frame  <= mark_frame;
            tx_sync   <= mark_frame && sync_pend;
            frame_cnt <= run_out ? frame_cnt + FRM_W'(1) : '0;

            // A request landing on a serviced frame stays pending for the next.
            if (st_d == ST_IDLE) begin
                sync_pend <= 1'b0;
            end else if (sync_req) begin
                sync_pend <= 1'b1;
            end else if (mark_frame) begin
                sync_pend <= 1'b0;
            end

            if (st_q == ST_IDLE && st_d == ST_PRIME) begin
                underflow <= 1'b0;
            end else if (st_q == ST_RUN && tx_enable && !pat_on && fifo_empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ddr_sample_tx.sv
// Randomized bench for ddr_sample_tx against a queue-based behavioural model.
// Define DDR_SAMPLE_TX_PATTERN_EN to also exercise the ramp pattern.
module tb_ddr_sample_tx;

    localparam int NBITS  = 12;
    localparam int DEPTH  = 4;
    localparam int PERIOD = 1024;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             tx_enable;
    logic             s_valid;
    logic             s_ready;
    logic [NBITS-1:0] s_d0;
    logic [NBITS-1:0] s_d1;
    logic             sync_req;
    logic             pattern_sel;
    logic [NBITS-1:0] tx_d0;
    logic [NBITS-1:0] tx_d1;
    logic             tx_frame;
    logic             tx_sync;
    logic             underflow;
    logic [1:0]       state;

    logic [NBITS-1:0] unused_dq_p;
    logic [NBITS-1:0] unused_dq_n;
    logic             unused_frame_p;
    logic             unused_frame_n;
    logic             unused_sync_p;
    logic             unused_sync_n;
    logic             unused_clk_p;
    logic             unused_clk_n;

    always #5 clk = ~clk;

    ddr_sample_tx #(.NBITS(NBITS), .FIFO_DEPTH(DEPTH), .SYNC_PERIOD(PERIOD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_enable  (tx_enable),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_d0       (s_d0),
        .s_d1       (s_d1),
        .sync_req   (sync_req),
        .pattern_sel(pattern_sel),
        .tx_d0      (tx_d0),
        .tx_d1      (tx_d1),
        .tx_frame   (tx_frame),
        .tx_sync    (tx_sync),
        .underflow  (underflow),
        .state      (state)
    );

    ddr_sample_oddr #(.NBITS(NBITS)) pins (
        .clk    (clk),
        .rst_n  (rst_n),
        .d0     (tx_d0),
        .d1     (tx_d1),
        .frame  (tx_frame),
        .sync   (tx_sync),
        .dq_p   (unused_dq_p),
        .dq_n   (unused_dq_n),
        .frame_p(unused_frame_p),
        .frame_n(unused_frame_n),
        .sync_p (unused_sync_p),
        .sync_n (unused_sync_n),
        .clk_p  (unused_clk_p),
        .clk_n  (unused_clk_n)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Model: 0=idle 1=prime 2=run; FIFO as a queue of {d1,d0} pairs.
    int               m_state = 0;
    logic [23:0]      m_q[$];
    int               m_pos = 0;
    int               m_ramp = 0;
    bit               m_pend = 0;
    bit               m_uf = 0;
    logic [NBITS-1:0] e_d0 = '0;
    logic [NBITS-1:0] e_d1 = '0;
    bit               e_frame = 0;
    bit               e_sync = 0;

    function automatic bit pat_active();
`ifdef DDR_SAMPLE_TX_PATTERN_EN
        return pattern_sel;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit model_ready();
        return rst_n && tx_enable && (m_q.size() != DEPTH);
    endfunction

    task automatic model_step();
        bit          push;
        bit          pat;
        int          nxt;
        logic [23:0] p;
        push = s_valid && model_ready();
        pat  = pat_active();
        if (!rst_n) begin
            m_state = 0; m_q.delete(); m_pos = 0; m_ramp = 0;
            m_pend = 0; m_uf = 0; e_d0 = '0; e_d1 = '0; e_frame = 0; e_sync = 0;
            return;
        end
        e_d0 = '0; e_d1 = '0; e_frame = 0; e_sync = 0;
        nxt = m_state;
        if (!tx_enable) begin
            nxt = 0; m_q.delete(); m_pend = 0; m_pos = 0;
        end else begin
            case (m_state)
                0: if (pat) nxt = 2; else begin nxt = 1; m_uf = 0; end
                1: if (pat || m_q.size() >= DEPTH / 2) nxt = 2;
                default: begin
                    if (pat || m_q.size() > 0) begin
                        if (pat) begin
                            e_d0   = 12'(m_ramp);
                            e_d1   = 12'((m_ramp + 1) % 4096);
                            m_ramp = (m_ramp + 2) % 4096;
                        end else begin
                            p    = m_q.pop_front();
                            e_d0 = p[11:0];
                            e_d1 = p[23:12];
                        end
                        e_frame = (m_pos == 0);
                        e_sync  = e_frame && m_pend;
                        if (e_sync) m_pend = 0;
                        m_pos = (m_pos + 1) % PERIOD;
                    end else begin
                        m_uf = 1; nxt = 1; m_pos = 0;
                    end
                end
            endcase
            if (sync_req) m_pend = 1;
            if (push) m_q.push_back({s_d1, s_d0});
        end
        if (m_state != 2) m_ramp = 0;
        m_state = nxt;
    endtask

    // Inputs are already set; check ready mid-cycle, then registered outputs after the edge.
    task automatic run_cycle();
        @(negedge clk);
        check_eq("s_ready", 32'(s_ready), 32'(model_ready()));
        model_step();
        @(posedge clk);
        #1;
        check_eq("tx_d0", 32'(tx_d0), 32'(e_d0));
        check_eq("tx_d1", 32'(tx_d1), 32'(e_d1));
        check_eq("tx_frame", 32'(tx_frame), 32'(e_frame));
        check_eq("tx_sync", 32'(tx_sync), 32'(e_sync));
        check_eq("underflow", 32'(underflow), 32'(m_uf));
        check_eq("state", 32'(state), 32'(m_state));
    endtask

    task automatic rand_data();
        s_d0 = 12'($urandom_range(0, 4095));
        s_d1 = 12'($urandom_range(0, 4095));
    endtask

    initial begin
        rst_n = 1'b0; tx_enable = 1'b0; s_valid = 1'b0; s_d0 = '0; s_d1 = '0;
        sync_req = 1'b0; pattern_sel = 1'b0;
        repeat (3) run_cycle();
        rst_n = 1'b1;
        run_cycle();

        // First two pairs prime the FIFO, then drain into underflow.
        tx_enable = 1'b1; s_valid = 1'b1; s_d0 = 12'd1; s_d1 = 12'd2;
        run_cycle();
        s_d0 = 12'd3; s_d1 = 12'd4;
        run_cycle();
        s_valid = 1'b0;
        repeat (6) run_cycle();

        // Continuous stream across several frames with sync requests.
        s_valid = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rand_data();
            sync_req = (i < 1100 && (m_pos == 500 || m_pos == 700)) || (i > 2000 && e_frame);
            run_cycle();
        end
        sync_req = 1'b0;

        // Starve the FIFO, then resume with bursty traffic.
        s_valid = 1'b0;
        repeat (8) run_cycle();
        for (int i = 0; i < 300; i++) begin
            rand_data();
            s_valid  = ($urandom_range(0, 1) == 1);
            sync_req = ($urandom_range(0, 99) == 0);
            run_cycle();
        end
        sync_req = 1'b0;

        tx_enable = 1'b0;
        repeat (2) run_cycle();

        // Mixed random traffic with enable drops and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            rand_data();
            tx_enable = ($urandom_range(0, 49) != 0);
            s_valid   = ($urandom_range(0, 3) != 0);
            sync_req  = ($urandom_range(0, 59) == 0);
            rst_n     = ($urandom_range(0, 399) != 0);
            run_cycle();
        end
        rst_n = 1'b1; sync_req = 1'b0; tx_enable = 1'b0; s_valid = 1'b0;
        repeat (2) run_cycle();

`ifdef DDR_SAMPLE_TX_PATTERN_EN
        // Ramp bypasses PRIME, fills the FIFO to full and wraps at 4096.
        rst_n = 1'b0;
        run_cycle();
        rst_n = 1'b1; tx_enable = 1'b1; pattern_sel = 1'b1; s_valid = 1'b1;
        for (int i = 0; i < 2100; i++) begin
            rand_data();
            sync_req = ($urandom_range(0, 199) == 0);
            run_cycle();
        end
        sync_req = 1'b0;
        tx_enable = 1'b0;
        repeat (3) run_cycle();
        pattern_sel = 1'b0; s_valid = 1'b0;
        run_cycle();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
